// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives all datapath controls.
// Latency 3..5+MEM_WAIT cycles per instruction; outputs are combinational from state and IR fields.
// Optional ILLEGAL_HALT_EN: unrecognised encodings enter a sticky HALT state instead of retiring as nop.
module mc_ctrl #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             ALUzero,
    output logic             IR_WE,
    output logic             PC_WE,
    output logic [1:0]       WACtrl,
    output logic [1:0]       WDCtrl,
    output logic [1:0]       ALUCtrl,
    output logic             ALUBCtrl,
    output logic             EXTCtrl,
    output logic [1:0]       JumpCtrl,
    output logic             DM_RE,
    output logic             DM_WE,
    output logic             GRFWE,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
`ifdef ILLEGAL_HALT_EN
    localparam logic [2:0] S_HALT   = 3'd5;
`endif

    logic [2:0] state, state_nxt;
    logic [3:0] wait_cnt;
    logic       mem_last;
    logic       ir_we_c;

    logic is_r, is_addu, is_subu, is_jr, is_nop;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic [1:0] alu_c;
    logic       alub_c, ext_c;

    assign is_r    = (opcode == 6'h00);
    assign is_addu = is_r && (funct == 6'h21);
    assign is_subu = is_r && (funct == 6'h23);
    assign is_jr   = is_r && (funct == 6'h08);
    assign is_nop  = is_r && (funct == 6'h00);
    assign is_ori  = (opcode == 6'h0d);
    assign is_lui  = (opcode == 6'h0f);
    assign is_lw   = (opcode == 6'h23);
    assign is_sw   = (opcode == 6'h2b);
    assign is_beq  = (opcode == 6'h04);
    assign is_j    = (opcode == 6'h02);
    assign is_jal  = (opcode == 6'h03);

    // ALU/EXT settings belong to the instruction, so MEM and WB simply keep presenting them.
    always_comb begin
        alu_c = 2'b00;
        if (is_subu || is_beq) alu_c = 2'b01;
        else if (is_ori)       alu_c = 2'b10;
        else if (is_lui)       alu_c = 2'b11;
    end
    assign alub_c   = is_ori || is_lui || is_lw || is_sw;
    assign ext_c    = is_lw || is_sw || is_beq;
    assign mem_last = (wait_cnt == 4'(MEM_WAIT));

    always_comb begin
        state_nxt = state;
        ir_we_c   = 1'b0;
        PC_WE     = 1'b0;
        WACtrl    = 2'b00;
        WDCtrl    = 2'b00;
        ALUCtrl   = 2'b00;
        ALUBCtrl  = 1'b0;
        EXTCtrl   = 1'b0;
        JumpCtrl  = 2'b00;
        DM_RE     = 1'b0;
        DM_WE     = 1'b0;
        GRFWE     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_we_c   = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                ALUCtrl  = alu_c;
                ALUBCtrl = alub_c;
                EXTCtrl  = ext_c;
                if (is_addu || is_subu || is_ori || is_lui) begin
                    state_nxt = S_WB;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else if (is_beq) begin
                    PC_WE     = 1'b1;
                    JumpCtrl  = ALUzero ? 2'b01 : 2'b00;
                    state_nxt = S_FETCH;
                end else if (is_j || is_jal) begin
                    PC_WE     = 1'b1;
                    JumpCtrl  = 2'b10;
                    GRFWE     = is_jal;
                    WACtrl    = is_jal ? 2'b10 : 2'b00;
                    WDCtrl    = is_jal ? 2'b10 : 2'b00;
                    state_nxt = S_FETCH;
                end else if (is_jr) begin
                    PC_WE     = 1'b1;
                    JumpCtrl  = 2'b11;
                    state_nxt = S_FETCH;
                end else if (is_nop) begin
                    PC_WE     = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
`ifdef ILLEGAL_HALT_EN
                    state_nxt = S_HALT;
`else
                    PC_WE     = 1'b1;
                    state_nxt = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                ALUCtrl  = alu_c;
                ALUBCtrl = alub_c;
                EXTCtrl  = ext_c;
                if (is_lw) begin
                    DM_RE = 1'b1;
                    if (mem_last) state_nxt = S_WB;
                end else if (mem_last) begin
                    // Store commits in its final MEM cycle, together with the DM write.
                    DM_WE     = 1'b1;
                    PC_WE     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                ALUCtrl   = alu_c;
                ALUBCtrl  = alub_c;
                EXTCtrl   = ext_c;
                GRFWE     = 1'b1;
                PC_WE     = 1'b1;
                WACtrl    = is_r ? 2'b01 : 2'b00;
                WDCtrl    = is_lw ? 2'b01 : 2'b00;
                state_nxt = S_FETCH;
            end
`ifdef ILLEGAL_HALT_EN
            S_HALT: state_nxt = S_HALT;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH; masking IR_WE keeps every enable low while reset is held.
    assign IR_WE = ir_we_c && reset;

`ifdef ILLEGAL_HALT_EN
    assign illegal = (state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
            retired  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_MEM && !mem_last) wait_cnt <= wait_cnt + 4'd1;
            else                             wait_cnt <= 4'd0;
            if (PC_WE) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: per-cycle expected control vectors from a reference model.
`timescale 1ns/1ps
module tb_mc_ctrl;
    localparam int MW = 2;
    localparam int CW = 4;
`ifdef ILLEGAL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] wa;
        logic [1:0] wd;
        logic [1:0] alu;
        logic       alub;
        logic       ext;
        logic [1:0] jump;
        logic       dm_re;
        logic       dm_we;
        logic       grfwe;
        logic       ill;
    } ctl_t;

    typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_NOP, K_ILL} kind_e;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode, funct;
    logic          ALUzero;
    logic          IR_WE, PC_WE, ALUBCtrl, EXTCtrl, DM_RE, DM_WE, GRFWE, illegal;
    logic [1:0]    WACtrl, WDCtrl, ALUCtrl, JumpCtrl;
    logic [CW-1:0] retired;

    ctl_t act;
    ctl_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int unsigned model_ret = 0;

    mc_ctrl #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .ALUzero(ALUzero),
        .IR_WE(IR_WE), .PC_WE(PC_WE), .WACtrl(WACtrl), .WDCtrl(WDCtrl), .ALUCtrl(ALUCtrl),
        .ALUBCtrl(ALUBCtrl), .EXTCtrl(EXTCtrl), .JumpCtrl(JumpCtrl), .DM_RE(DM_RE),
        .DM_WE(DM_WE), .GRFWE(GRFWE), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {IR_WE, PC_WE, WACtrl, WDCtrl, ALUCtrl, ALUBCtrl, EXTCtrl, JumpCtrl,
                  DM_RE, DM_WE, GRFWE, illegal};

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                       6'h21:   return K_ADDU;
                       6'h23:   return K_SUBU;
                       6'h08:   return K_JR;
                       6'h00:   return K_NOP;
                       default: return K_ILL;
                   endcase
            6'h0d:   return K_ORI;
            6'h0f:   return K_LUI;
            6'h23:   return K_LW;
            6'h2b:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // Reference model: the full cycle-by-cycle control trace of one instruction, from the ISA table.
    task automatic model_push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              output int n, output bit commit);
        kind_e k;
        ctl_t  c, alu;
        k = classify(op, fn);
        alu = '0;
        case (k)
            K_SUBU:     alu.alu = 2'b01;
            K_ORI:      begin alu.alu = 2'b10; alu.alub = 1'b1; end
            K_LUI:      begin alu.alu = 2'b11; alu.alub = 1'b1; end
            K_LW, K_SW: begin alu.alub = 1'b1; alu.ext = 1'b1; end
            K_BEQ:      begin alu.alu = 2'b01; alu.ext = 1'b1; end
            default:    alu = '0;
        endcase
        c = '0; c.ir_we = 1'b1;
        exp_q.push_back(c);
        exp_q.push_back(ctl_t'(0));
        commit = 1'b1;
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                exp_q.push_back(alu);
                c = alu; c.grfwe = 1'b1; c.pc_we = 1'b1;
                c.wa = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
                exp_q.push_back(c);
                n = 4;
            end
            K_LW: begin
                exp_q.push_back(alu);
                for (int i = 0; i <= MW; i++) begin
                    c = alu; c.dm_re = 1'b1; exp_q.push_back(c);
                end
                c = alu; c.grfwe = 1'b1; c.pc_we = 1'b1; c.wd = 2'b01;
                exp_q.push_back(c);
                n = 5 + MW;
            end
            K_SW: begin
                exp_q.push_back(alu);
                for (int i = 0; i < MW; i++) exp_q.push_back(alu);
                c = alu; c.dm_we = 1'b1; c.pc_we = 1'b1;
                exp_q.push_back(c);
                n = 4 + MW;
            end
            K_ILL: begin
                if (HALT_EN) begin
                    exp_q.push_back(ctl_t'(0));
                    c = '0; c.ill = 1'b1;
                    for (int i = 0; i < 3; i++) exp_q.push_back(c);
                    n = 6;
                    commit = 1'b0;
                end else begin
                    c = '0; c.pc_we = 1'b1; exp_q.push_back(c);
                    n = 3;
                end
            end
            default: begin
                c = alu; c.pc_we = 1'b1;
                case (k)
                    K_BEQ:   c.jump = z ? 2'b01 : 2'b00;
                    K_J:     c.jump = 2'b10;
                    K_JAL:   begin c.jump = 2'b10; c.grfwe = 1'b1; c.wa = 2'b10; c.wd = 2'b10; end
                    K_JR:    c.jump = 2'b11;
                    default: c.jump = 2'b00;
                endcase
                exp_q.push_back(c);
                n = 3;
            end
        endcase
    endtask

    // Monitor: every cycle either checks the reset-quiet outputs or pops the next expected vector.
    always @(negedge clk) begin
        ctl_t e;
        cyc++;
        if (!reset) begin
            tests++;
            if (act !== ctl_t'(0) || retired !== '0) begin
                fails++;
                $display("FAIL reset_quiet cyc=%0d ctl=%h retired=%0d required ctl=0 retired=0", cyc, act, retired);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL ctl_trace cyc=%0d op=%h fn=%h z=%b got=%h required=%h", cyc, opcode, funct, ALUzero, act, e);
            end
        end
    end

    task automatic check_retired(input string tag);
        tests++;
        if (retired !== CW'(model_ret)) begin
            fails++;
            $display("FAIL %s retired=%0d required=%0d", tag, retired, CW'(model_ret));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_ret = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        bit commit;
        opcode = op; funct = fn; ALUzero = z;
        model_push(op, fn, z, n, commit);
        repeat (n) @(posedge clk);
        #1;
        if (commit) model_ret++;
        check_retired(commit ? "retire_count" : "halt_no_retire");
        if (!commit) do_reset();
    endtask

    logic [5:0] tbl_op [11];
    logic [5:0] tbl_fn [11];

    initial begin
        tbl_op = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h00, 6'h00};
        tbl_fn = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00};
        reset = 1'b0; opcode = 6'h00; funct = 6'h21; ALUzero = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_retired("reset_retired");
        reset = 1'b1;

        // Directed: addu, lw, beq taken/not-taken, jal, j, jr, ori, lui, nop.
        issue(6'h00, 6'h21, 1'b0);
        issue(6'h23, 6'h15, 1'b0);
        issue(6'h04, 6'h00, 1'b1);
        issue(6'h04, 6'h00, 1'b0);
        issue(6'h03, 6'h3f, 1'b0);
        issue(6'h02, 6'h00, 1'b1);
        issue(6'h00, 6'h08, 1'b0);
        issue(6'h0d, 6'h21, 1'b0);
        issue(6'h0f, 6'h00, 1'b1);
        issue(6'h00, 6'h00, 1'b0);

        // Reset arrives in the store's final MEM cycle: DM_WE must never appear, retired clears.
        begin
            int n;
            bit commit;
            opcode = 6'h2b; funct = 6'h00; ALUzero = 1'b0;
            model_push(6'h2b, 6'h00, 1'b0, n, commit);
            repeat (3 + MW) @(posedge clk);
            #1 do_reset();
            check_retired("sw_abort_retired");
        end
        issue(6'h2b, 6'h07, 1'b0);

        // Illegal opcode: halts under the option, otherwise retires as nop.
        issue(6'h3f, 6'h3f, 1'b0);

        for (int i = 0; i < 70; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 17) issue(tbl_op[r % 11], (tbl_op[r % 11] == 6'h00) ? tbl_fn[r % 11] : 6'($urandom),
                              1'($urandom));
            else        issue(6'($urandom), 6'($urandom), 1'($urandom));
        end

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL trace_drain left=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
